// File: rtl/fpu_add_reduce_pkg.sv
// Shared types and constants for the streaming binary32 sum-reduction sequencer.
package fpu_add_reduce_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    OUT   = 2'd3
  } state_t;

  localparam int FP32_W = 32;
  localparam logic [FP32_W-1:0] FP32_POS_ZERO = 32'h0000_0000;

endpackage

// File: rtl/fpu_add_reduce.sv
// Packet sum-reduction initiator for an external FPUAdd: issues acc+x per element,
// waits for each result (with timeout) and emits the packet sum on an AXI-stream master.
module fpu_add_reduce
  import fpu_add_reduce_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 64,
  parameter int CNT_W          = 16
) (
  input  logic              aclk,
  input  logic              aresetn,
  input  logic [31:0]       s_axis_tdata,
  input  logic              s_axis_tvalid,
  output logic              s_axis_tready,
  input  logic              s_axis_tlast,
  output logic [31:0]       fpu_a_tdata,
  output logic              fpu_a_tvalid,
  output logic [31:0]       fpu_b_tdata,
  output logic              fpu_b_tvalid,
  input  logic              fpu_result_tvalid,
  input  logic [31:0]       fpu_result_tdata,
  output logic [31:0]       m_axis_tdata,
  output logic              m_axis_tvalid,
  input  logic              m_axis_tready,
  output logic              m_axis_tuser,
  output logic [CNT_W-1:0]  m_axis_count,
  output logic              err_timeout,
  output logic              err_spurious
);

  localparam int TMR_W = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(TIMEOUT_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};

  state_t              state_r;
  state_t              state_next_s;
  logic [FP32_W-1:0]   acc_r;
  logic [FP32_W-1:0]   x_r;
  logic                last_r;
  logic [CNT_W-1:0]    count_r;
  logic                pkt_err_r;
  logic [TMR_W-1:0]    timer_r;
  logic                op_tvalid_r;
  logic                m_tvalid_r;
  logic                err_timeout_r;
  logic                err_spurious_r;

  logic                accept_s;
  logic                result_take_s;
  logic                timeout_s;
  logic                out_hs_s;

  // Next-state and per-cycle event decode
  always_comb begin
    state_next_s  = state_r;
    accept_s      = 1'b0;
    result_take_s = 1'b0;
    timeout_s     = 1'b0;
    out_hs_s      = 1'b0;
    case (state_r)
      IDLE: begin
        if (s_axis_tvalid) begin
          accept_s     = 1'b1;
          state_next_s = ISSUE;
        end else begin
          state_next_s = IDLE;
        end
      end
      ISSUE: begin
        state_next_s = WAIT;
      end
      WAIT: begin
        if (fpu_result_tvalid) begin
          result_take_s = 1'b1;
          state_next_s  = last_r ? OUT : IDLE;
        end else if (timer_r == TMR_LAST) begin
          // Abandon the element and close the packet with what has been summed.
          timeout_s    = 1'b1;
          state_next_s = OUT;
        end else begin
          state_next_s = WAIT;
        end
      end
      OUT: begin
        if (m_axis_tready) begin
          out_hs_s     = 1'b1;
          state_next_s = IDLE;
        end else begin
          state_next_s = OUT;
        end
      end
      default: begin
        state_next_s = IDLE;
      end
    endcase
  end

  // State register
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_next_s;
    end
  end

  // Element latch, wait timer, accumulator, counter and packet error bit
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      x_r       <= FP32_POS_ZERO;
      last_r    <= 1'b0;
      timer_r   <= {TMR_W{1'b0}};
      acc_r     <= FP32_POS_ZERO;
      count_r   <= {CNT_W{1'b0}};
      pkt_err_r <= 1'b0;
    end else begin
      if (accept_s) begin
        x_r    <= s_axis_tdata;
        last_r <= s_axis_tlast;
      end
      if (state_r == ISSUE) begin
        timer_r <= {TMR_W{1'b0}};
      end else if (state_r == WAIT) begin
        timer_r <= timer_r + {{(TMR_W-1){1'b0}}, 1'b1};
      end
      if (result_take_s) begin
        acc_r   <= fpu_result_tdata;
        count_r <= (count_r == CNT_MAX) ? CNT_MAX : count_r + {{(CNT_W-1){1'b0}}, 1'b1};
      end else if (out_hs_s) begin
        acc_r   <= FP32_POS_ZERO;
        count_r <= {CNT_W{1'b0}};
      end
      if (timeout_s) begin
        pkt_err_r <= 1'b1;
      end else if (out_hs_s) begin
        pkt_err_r <= 1'b0;
      end
    end
  end

  // Registered valids and sticky error flags
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      op_tvalid_r    <= 1'b0;
      m_tvalid_r     <= 1'b0;
      err_timeout_r  <= 1'b0;
      err_spurious_r <= 1'b0;
    end else begin
      op_tvalid_r <= (state_next_s == ISSUE);
      m_tvalid_r  <= (state_next_s == OUT);
      if (timeout_s) begin
        err_timeout_r <= 1'b1;
      end
      // Any result outside WAIT is stale or unsolicited and is dropped.
      if (fpu_result_tvalid && (state_r != WAIT)) begin
        err_spurious_r <= 1'b1;
      end
    end
  end

  assign s_axis_tready = (state_r == IDLE);
  assign fpu_a_tdata   = acc_r;
  assign fpu_b_tdata   = x_r;
  assign fpu_a_tvalid  = op_tvalid_r;
  assign fpu_b_tvalid  = op_tvalid_r;
  assign m_axis_tdata  = acc_r;
  assign m_axis_tvalid = m_tvalid_r;
  assign m_axis_tuser  = pkt_err_r;
  assign m_axis_count  = count_r;
  assign err_timeout   = err_timeout_r;
  assign err_spurious  = err_spurious_r;

endmodule

// File: tb/tb_fpu_add_reduce.sv
// Self-checking bench: behavioural FPUAdd (real arithmetic, configurable latency/drop),
// directed scenarios plus randomized integer-valued packets against a plain-sum model.
module tb_fpu_add_reduce;

  logic        aclk;
  logic        aresetn;
  logic [31:0] s_axis_tdata;
  logic        s_axis_tvalid;
  logic        s_axis_tready;
  logic        s_axis_tlast;
  logic [31:0] fpu_a_tdata;
  logic        fpu_a_tvalid;
  logic [31:0] fpu_b_tdata;
  logic        fpu_b_tvalid;
  logic        fpu_result_tvalid;
  logic [31:0] fpu_result_tdata;
  logic [31:0] m_axis_tdata;
  logic        m_axis_tvalid;
  logic        m_axis_tready;
  logic        m_axis_tuser;
  logic [15:0] m_axis_count;
  logic        err_timeout;
  logic        err_spurious;

  fpu_add_reduce #(.TIMEOUT_CYCLES(64), .CNT_W(16)) dut (
    .aclk(aclk), .aresetn(aresetn),
    .s_axis_tdata(s_axis_tdata), .s_axis_tvalid(s_axis_tvalid),
    .s_axis_tready(s_axis_tready), .s_axis_tlast(s_axis_tlast),
    .fpu_a_tdata(fpu_a_tdata), .fpu_a_tvalid(fpu_a_tvalid),
    .fpu_b_tdata(fpu_b_tdata), .fpu_b_tvalid(fpu_b_tvalid),
    .fpu_result_tvalid(fpu_result_tvalid), .fpu_result_tdata(fpu_result_tdata),
    .m_axis_tdata(m_axis_tdata), .m_axis_tvalid(m_axis_tvalid),
    .m_axis_tready(m_axis_tready), .m_axis_tuser(m_axis_tuser),
    .m_axis_count(m_axis_count),
    .err_timeout(err_timeout), .err_spurious(err_spurious)
  );

  initial begin
    aclk = 1'b0;
    forever #5 aclk = ~aclk;
  end

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %08h want %08h", tag, obs, exp);
  endtask

  // binary32 <-> real for normal numbers and zero (enough for the values used here)
  function automatic real f2r(input logic [31:0] f);
    logic [63:0] d;
    logic [10:0] e;
    if (f[30:0] == 31'd0) begin
      d = {f[31], 63'd0};
    end else begin
      e = {3'd0, f[30:23]} + 11'd896;
      d = {f[31], e, f[22:0], 29'd0};
    end
    return $bitstoreal(d);
  endfunction

  function automatic logic [31:0] r2f(input real r);
    logic [63:0] d;
    logic [10:0] e;
    d = $realtobits(r);
    if (d[62:0] == 63'd0) return {d[63], 31'd0};
    e = d[62:52] - 11'd896;
    return {d[63], e[7:0], d[51:29]};
  endfunction

  // Behavioural adder: answers lat cycles after operand sampling unless told to drop
  int          lat = 3;
  int          ops = 0;
  int          drop_op = -1;
  int          pend = 0;
  int          ab_mis = 0;
  int          inj_req = 0;
  int          inj_done = 0;
  logic [31:0] inj_data = 32'h0;
  logic [31:0] pend_data = 32'h0;
  logic [31:0] last_a = 32'h0;
  logic [31:0] last_b = 32'h0;

  initial begin
    fpu_result_tvalid = 1'b0;
    fpu_result_tdata  = 32'h0;
    forever begin
      @(negedge aclk);
      fpu_result_tvalid = 1'b0;
      if (inj_req != inj_done) begin
        inj_done          = inj_req;
        fpu_result_tvalid = 1'b1;
        fpu_result_tdata  = inj_data;
      end else if (pend > 0) begin
        pend--;
        if (pend == 0) begin
          fpu_result_tvalid = 1'b1;
          fpu_result_tdata  = pend_data;
        end
      end
      if (fpu_a_tvalid !== fpu_b_tvalid) ab_mis++;
      if (fpu_a_tvalid === 1'b1) begin
        ops++;
        last_a = fpu_a_tdata;
        last_b = fpu_b_tdata;
        if (ops != drop_op) begin
          pend      = lat;
          pend_data = r2f(f2r(fpu_a_tdata) + f2r(fpu_b_tdata));
        end
      end
    end
  end

  task automatic send_elem(input logic [31:0] d, input logic last);
    int n;
    n = 0;
    @(negedge aclk);
    while (s_axis_tready !== 1'b1 && n < 200) begin
      @(negedge aclk);
      n++;
    end
    if (n >= 200) check_val("in_ready_wait", 32'd0, 32'd1);
    s_axis_tdata  = d;
    s_axis_tlast  = last;
    s_axis_tvalid = 1'b1;
    @(posedge aclk);
    #1;
    s_axis_tvalid = 1'b0;
    s_axis_tlast  = 1'b0;
  endtask

  // Called right after the last element is accepted; exp_wait counts falling edges until tvalid
  task automatic recv_sum(input string tag, input logic [31:0] exp_d, input int exp_cnt,
                          input logic exp_user, input int exp_wait, input int hold);
    int n;
    n = 1;
    @(negedge aclk);
    while (m_axis_tvalid !== 1'b1 && n < 300) begin
      @(negedge aclk);
      n++;
    end
    if (m_axis_tvalid !== 1'b1) begin
      check_val({tag, "_out_wait"}, 32'd0, 32'd1);
      return;
    end
    check_val({tag, "_lat"}, 32'(n), 32'(exp_wait));
    check_val({tag, "_data"}, m_axis_tdata, exp_d);
    check_val({tag, "_count"}, 32'(m_axis_count), 32'(exp_cnt));
    check_val({tag, "_tuser"}, {31'd0, m_axis_tuser}, {31'd0, exp_user});
    for (int i = 0; i < hold; i++) begin
      @(negedge aclk);
      check_val({tag, "_hold_valid"}, {31'd0, m_axis_tvalid}, 32'd1);
      check_val({tag, "_hold_data"}, m_axis_tdata, exp_d);
      check_val({tag, "_hold_count"}, 32'(m_axis_count), 32'(exp_cnt));
      check_val({tag, "_hold_tuser"}, {31'd0, m_axis_tuser}, {31'd0, exp_user});
      check_val({tag, "_hold_sready"}, {31'd0, s_axis_tready}, 32'd0);
    end
    m_axis_tready = 1'b1;
    @(posedge aclk);
    #1;
    m_axis_tready = 1'b0;
    check_val({tag, "_idle_sready"}, {31'd0, s_axis_tready}, 32'd1);
    check_val({tag, "_idle_mvalid"}, {31'd0, m_axis_tvalid}, 32'd0);
  endtask

  task automatic check_reset_outputs(input string tag);
    check_val({tag, "_sready"}, {31'd0, s_axis_tready}, 32'd1);
    check_val({tag, "_avalid"}, {31'd0, fpu_a_tvalid}, 32'd0);
    check_val({tag, "_bvalid"}, {31'd0, fpu_b_tvalid}, 32'd0);
    check_val({tag, "_adata"}, fpu_a_tdata, 32'h0);
    check_val({tag, "_bdata"}, fpu_b_tdata, 32'h0);
    check_val({tag, "_mvalid"}, {31'd0, m_axis_tvalid}, 32'd0);
    check_val({tag, "_mdata"}, m_axis_tdata, 32'h0);
    check_val({tag, "_mcount"}, 32'(m_axis_count), 32'd0);
    check_val({tag, "_mtuser"}, {31'd0, m_axis_tuser}, 32'd0);
    check_val({tag, "_etmo"}, {31'd0, err_timeout}, 32'd0);
    check_val({tag, "_espur"}, {31'd0, err_spurious}, 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want completion");
    $fatal(1);
  end

  initial begin
    int ops0;
    int len;
    int sum;
    int v;
    aresetn       = 1'b1;
    s_axis_tdata  = 32'h0;
    s_axis_tvalid = 1'b0;
    s_axis_tlast  = 1'b0;
    m_axis_tready = 1'b0;
    #2 aresetn = 1'b0;
    #1 check_reset_outputs("rst");
    repeat (2) @(negedge aclk);
    aresetn = 1'b1;

    // 1.0 + 2.0 + 3.0 = 6.0
    lat  = 3;
    ops0 = ops;
    send_elem(32'h3F80_0000, 1'b0);
    send_elem(32'h4000_0000, 1'b0);
    send_elem(32'h4040_0000, 1'b1);
    recv_sum("sum3", 32'h40C0_0000, 3, 1'b0, lat + 2, 0);
    check_val("sum3_ops", 32'(ops - ops0), 32'd3);

    // Single element: 0 + pi
    send_elem(32'h4049_0FDB, 1'b1);
    recv_sum("single", 32'h4049_0FDB, 1, 1'b0, lat + 2, 0);
    check_val("single_opA", last_a, 32'h0000_0000);
    check_val("single_opB", last_b, 32'h4049_0FDB);

    // Output back-pressure
    lat = 2;
    send_elem(32'h4000_0000, 1'b1);
    recv_sum("bp", 32'h4000_0000, 1, 1'b0, lat + 2, 5);

    // Adder never answers the 2nd op: 1 ISSUE + 64 WAIT cycles, then OUT
    lat     = 1;
    drop_op = ops + 2;
    send_elem(32'h3F80_0000, 1'b0);
    send_elem(32'h4000_0000, 1'b1);
    recv_sum("tmo", 32'h3F80_0000, 1, 1'b1, 66, 0);
    check_val("tmo_err", {31'd0, err_timeout}, 32'd1);
    check_val("tmo_no_spur", {31'd0, err_spurious}, 32'd0);
    drop_op = -1;

    // Unsolicited result in IDLE
    @(negedge aclk);
    inj_data = 32'h1234_5678;
    inj_req++;
    repeat (2) @(negedge aclk);
    check_val("spur_err", {31'd0, err_spurious}, 32'd1);
    lat = 3;
    send_elem(32'h3F80_0000, 1'b1);
    recv_sum("spur_next", 32'h3F80_0000, 1, 1'b0, lat + 2, 0);

    // Reset while waiting on the 2nd op (acc already 2.0)
    lat = 10;
    send_elem(32'h4000_0000, 1'b0);
    send_elem(32'h3F80_0000, 1'b1);
    repeat (3) @(negedge aclk);
    check_val("prerst_acc", fpu_a_tdata, 32'h4000_0000);
    #2 aresetn = 1'b0;
    #1 check_reset_outputs("midrst");
    @(negedge aclk);
    aresetn = 1'b1;
    repeat (12) @(negedge aclk);
    check_val("late_spur", {31'd0, err_spurious}, 32'd1);
    lat = 3;
    send_elem(32'h3F80_0000, 1'b1);
    recv_sum("postrst", 32'h3F80_0000, 1, 1'b0, lat + 2, 0);
    check_val("postrst_opA", last_a, 32'h0000_0000);

    // Randomized packets of small integers (sums stay exact in binary32)
    for (int p = 0; p < 25; p++) begin
      len  = $urandom_range(1, 5);
      lat  = $urandom_range(1, 6);
      sum  = 0;
      ops0 = ops;
      for (int i = 0; i < len; i++) begin
        v   = $urandom_range(0, 1000);
        sum = sum + v;
        send_elem(r2f(real'(v)), (i == len - 1));
      end
      recv_sum("rnd", r2f(real'(sum)), len, 1'b0, lat + 2, $urandom_range(0, 2));
      check_val("rnd_ops", 32'(ops - ops0), 32'(len));
    end

    check_val("ab_valid_match", 32'(ab_mis), 32'd0);
    check_val("end_etmo", {31'd0, err_timeout}, 32'd0);
    check_val("end_espur", {31'd0, err_spurious}, 32'd1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/fpu_add_reduce.md
# fpu_add_reduce

Streaming sum-reduction sequencer that acts as the initiator for the single-precision `FPUAdd` operand/result interface. It accepts a packetised stream of IEEE-754 binary32 values and issues one add per element to the adder as `acc + x`. It waits for each result before issuing the next add, and emits the packet sum on an AXI-stream master. It sits between a data source (DMA or accelerator output) and the `FPUAdd` instance, on the same `aclk` domain.

## Interface
Parameters:
- `TIMEOUT_CYCLES`, default 64: maximum cycles spent in WAIT for an adder result before the op is abandoned; legal range 2..2^16.
- `CNT_W`, default 16: width of the per-packet element counter.

Ports:
- `aclk`  in  1  sole clock. Everything is sampled on the rising edge.
- `aresetn`  in  1  asynchronous, active-low reset.
- `s_axis_tdata`  in  32  input element, binary32.
- `s_axis_tvalid`  in  1  input element valid.
- `s_axis_tready`  out  1  input accept.
- `s_axis_tlast`  in  1  marks the final element of a packet.
- `fpu_a_tdata`  out  32  adder operand A, which is the accumulator.
- `fpu_a_tvalid`  out  1  operand A valid; a one-cycle pulse.
- `fpu_b_tdata`  out  32  adder operand B, which is the latched element.
- `fpu_b_tvalid`  out  1  operand B valid; a one-cycle pulse, always identical to `fpu_a_tvalid`.
- `fpu_result_tvalid`  in  1  adder result valid.
- `fpu_result_tdata`  in  32  adder result.
- `m_axis_tdata`  out  32  packet sum.
- `m_axis_tvalid`  out  1  sum valid.
- `m_axis_tready`  in  1  sum accept.
- `m_axis_tuser`  out  1  set to 1 if a timeout occurred while reducing this packet.
- `m_axis_count`  out  CNT_W  number of elements successfully accumulated in this packet.
- `err_timeout`  out  1  sticky flag; cleared only by reset.
- `err_spurious`  out  1  sticky flag; cleared only by reset.

## Operation
- The FSM states are IDLE, ISSUE, WAIT and OUT. The reset state is IDLE.
- Reset values:
  - all outputs are 0, except `s_axis_tready`, which is 1 because it is high in IDLE;
  - the accumulator is 32'h0000_0000 (+0.0);
  - the element counter is 0;
  - the packet error bit is 0.
- IDLE:
  - `s_axis_tready`=1.
  - On `s_axis_tvalid`&&`s_axis_tready`, latch `tdata` into x and `tlast` into the last flag, then go to ISSUE.
- ISSUE:
  - Registered outputs drive `fpu_a_tdata`=acc, `fpu_b_tdata`=x and both tvalid=1 for exactly one cycle.
  - Clear the timer, then go to WAIT.
- WAIT:
  - The operand tvalids are 0 and the timer increments each cycle.
  - If `fpu_result_tvalid`=1: acc←`fpu_result_tdata` and count←count+1, saturating at 2^CNT_W−1. Go to OUT if the last flag is set, otherwise go to IDLE.
  - Else if timer==TIMEOUT_CYCLES−1: set `err_timeout` and the packet error bit, leave acc and count unchanged, and treat the element as last, going to OUT. The current element is dropped. If the input had not yet reached `tlast`, subsequent elements of that packet start a new reduction.
- OUT:
  - `m_axis_tvalid`=1, with `tdata`=acc, `count`=count and `tuser`=the packet error bit. These values stay stable until `m_axis_tready`=1.
  - On the handshake: acc←+0.0, count←0, packet error←0, go to IDLE.
- `fpu_result_tvalid`=1 in any state other than WAIT is discarded and sets `err_spurious`. This includes late results after a timeout and results from an op issued before a mid-operation reset.
- No floating-point arithmetic is done locally. Values pass through bit-exact; NaN and ±Inf are propagated as returned by the adder.

## Timing
- An input accepted at edge T gives operand valid in cycle T+1.
- A result arriving L cycles after operand sampling is absorbed on that edge.
- The earliest possible next `s_axis_tready`=1 is one cycle after the result when not last.
- Per-element cost is 2+L cycles. For a packet whose last result arrives at edge R, `m_axis_tvalid` rises in cycle R+1.
- `s_axis_tready` is combinational from state only: it is high only in IDLE. There is no combinational path from `m_axis_tready` or `fpu_result_tvalid` to any output.
- With a 1-element packet, the sum equals 0+x as computed by the adder.
- Asserting `aresetn` low in any state forces all outputs to their reset values immediately. No pending operand pulse is completed.

## Structure
- Package `fpu_add_reduce_pkg` holds:
  - the `state_t` enum (IDLE/ISSUE/WAIT/OUT);
  - `FP32_W`=32;
  - `FP32_POS_ZERO`=32'h0000_0000.
- A single flat module. The timer and counter are inline, and no sub-module is needed.

## Test plan
- Directed sum: send 1.0 (3F800000), 2.0 (40000000) and 3.0 (40400000, tlast) through a behavioural adder with L=3. Expect `m_axis_tdata`=40C00000, count=3 and tuser=0, with exactly 3 operand pulses.
- Single element: send 40490FDB with tlast. Expect operand pulse A=00000000, B=40490FDB, then a sum of 40490FDB with count=1.
- Back-pressure: hold `m_axis_tready`=0 for 5 cycles in OUT. Expect `tvalid`, `tdata`, `count` and `tuser` stable, `s_axis_tready`=0 throughout, and IDLE entered on the cycle after the handshake.
- Timeout: use TIMEOUT_CYCLES=64 with an adder that never answers the 2nd element of {1.0, 2.0(tlast)}. On the 64th WAIT cycle, expect `err_timeout`=1. The output is 3F800000 with count=1 and tuser=1.
- Spurious result: pulse `fpu_result_tvalid` in IDLE with data 12345678. Expect `err_spurious`=1, and acc unaffected: the next packet {1.0, tlast} sums to 3F800000.
- Reset mid-op: drop `aresetn` during WAIT. Expect all outputs at reset values without waiting for a clock edge. A later result sets `err_spurious`, and the next packet sums from +0.0.
